tx_shift: RTL

Byte serializer for the AES core's UART output path. Captures a 128-bit block (ciphertext from the AES core) on a load pulse and hands it to the UART transmitter one byte at a time, MSB byte first. This mirrors the receive-side shift register's byte order, so a block looped through UART TX and RX arrives unchanged.

---
 rtl/tx_shift_if.sv | 23 ++
 rtl/tx_shift.sv | 83 ++++++++
 2 files changed

// File: rtl/tx_shift_if.sv
// Byte-serializer handshake bundle: block load on one side,
// byte-wide UART transmit handshake on the other.
interface tx_shift_if #(
    parameter int NBYTES = 16
);
    logic [8*NBYTES-1:0] d_in;
    logic                load;
    logic                tx_done;
    logic [7:0]          d_out;
    logic                tx_start;
    logic                busy;
    logic                shift_done;

    modport master (
        output d_in, load, tx_done,
        input  d_out, tx_start, busy, shift_done
    );

    modport slave (
        input  d_in, load, tx_done,
        output d_out, tx_start, busy, shift_done
    );
endinterface

// File: rtl/tx_shift.sv
// Captures a block on load and hands it to the UART TX one byte
// at a time, MSB byte first, matching the receive-side byte order.
module tx_shift #(
    parameter int NBYTES = 16
) (
    input logic clk,
    input logic reset,
    tx_shift_if.slave io
);
    localparam int W  = 8 * NBYTES;
    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT
    } state_e;

    state_e        state_q;
    logic [W-1:0]  sreg_q;
    logic [W-1:0]  sreg_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          start_q;
    logic          busy_q;
    logic          sdone_q;

    assign sreg_d = sreg_q << 8;
    assign cnt_d  = cnt_q + CW'(1);

    // d_out is the top byte of the shift register, so it only moves
    // on the edges that load or shift, i.e. the edges entering START.
    assign io.d_out      = sreg_q[W-1 -: 8];
    assign io.tx_start   = start_q;
    assign io.busy       = busy_q;
    assign io.shift_done = sdone_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            sdone_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            sdone_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (io.load) begin
                        sreg_q  <= io.d_in;
                        cnt_q   <= '0;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (io.tx_done) begin
                        if (cnt_q == LAST) begin
                            busy_q  <= 1'b0;
                            sdone_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            sreg_q  <= sreg_d;
                            cnt_q   <= cnt_d;
                            start_q <= 1'b1;
                            state_q <= START;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule
